// File: rtl/tx_queue_sched.sv
// TX queue scheduler: grants one eligible queue, pops its meta/TSF words, holds the
// packet until its TSF launch time, then meters data-word reads to the bit interface.
module tx_queue_sched #(
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int TSF_TIMER_WIDTH        = 64,
  parameter int UNDERRUN_TIMEOUT       = 1023,
  parameter int UR_CNT_W               = 10
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic [2:0]                        queue_en,
  input  logic                              strict_prio,
  input  logic [2:0]                        meta_empty,
  input  logic                              EMPTYN_TO_ACC,
  input  logic [63:0]                       DMG_TO_ACC,
  input  logic [TSF_TIMER_WIDTH-1:0]        TSF_TO_ACC,
  input  logic [TSF_TIMER_WIDTH-1:0]        tsf_now,
  input  logic                              tx_phy_ready,
  input  logic                              data_req,
  output logic [1:0]                        tx_queue_idx,
  output logic                              ACC_ASK_DMG,
  output logic                              ACC_ASK_TSF,
  output logic                              ACC_ASK_DATA,
  output logic [31:0]                       cts_toself_config,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_num_word,
  output logic                              pkt_start,
  output logic                              pkt_done,
  output logic                              underrun_err,
  output logic                              busy
);
  localparam int W = MAX_BIT_NUM_DMA_SYMBOL;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_WAIT_TSF, S_STREAM, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [1:0]                 rr_last_q, rr_last_d;
  logic [31:0]                cts_q, cts_d;
  logic [W-1:0]               num_q, num_d;
  logic [W-1:0]               rem_q, rem_d;
  logic [TSF_TIMER_WIDTH-1:0] tsf_target_q, tsf_target_d;
  logic [UR_CNT_W-1:0]        ur_q, ur_d;
  logic                       abort_q, abort_d;

  logic [2:0] eligible;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       launch;
  logic       data_stb;
  logic       stall;
  logic       run;
  logic       unused_dmg;

  assign unused_dmg = ^DMG_TO_ACC[31:W];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_elig
      assign eligible[gi] = queue_en[gi] & ~meta_empty[gi];
    end
  endgenerate

  // Loops run from lowest to highest priority so the preferred candidate is written last.
  always_comb begin
    grant_idx = 2'd0;
    cand      = 2'd0;
    if (strict_prio) begin
      for (int i = 2; i >= 0; i--) begin
        if (eligible[i]) grant_idx = 2'(i);
      end
    end else begin
      for (int k = 3; k >= 1; k--) begin
        cand = 2'((int'(rr_last_q) + k) % 3);
        if (eligible[cand]) grant_idx = cand;
      end
    end
  end

  // Strobes and pulses are masked while reset is held so no FIFO is touched during reset.
  assign run      = ~S_AXIS_ARESET;
  assign launch   = (tsf_target_q == '0) || (tsf_now >= tsf_target_q);
  assign data_stb = (state_q == S_STREAM) && data_req && EMPTYN_TO_ACC && (rem_q != '0);
  assign stall    = data_req & ~EMPTYN_TO_ACC;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      rr_last_q    <= 2'd2;
      cts_q        <= '0;
      num_q        <= '0;
      rem_q        <= '0;
      tsf_target_q <= '0;
      ur_q         <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rr_last_q    <= rr_last_d;
      cts_q        <= cts_d;
      num_q        <= num_d;
      rem_q        <= rem_d;
      tsf_target_q <= tsf_target_d;
      ur_q         <= ur_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rr_last_d    = rr_last_q;
    cts_d        = cts_q;
    num_d        = num_q;
    rem_d        = rem_q;
    tsf_target_d = tsf_target_q;
    ur_d         = ur_q;
    abort_d      = abort_q;
    ACC_ASK_DMG  = 1'b0;
    ACC_ASK_TSF  = 1'b0;
    ACC_ASK_DATA = 1'b0;
    pkt_start    = 1'b0;
    pkt_done     = 1'b0;
    underrun_err = 1'b0;
    busy         = run && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (tx_phy_ready && (|eligible)) begin
          idx_d   = grant_idx;
          state_d = S_POP;
        end
      end
      S_POP: begin
        ACC_ASK_DMG = run;
        ACC_ASK_TSF = run;
        state_d     = S_LATCH;
      end
      S_LATCH: begin
        cts_d        = DMG_TO_ACC[63:32];
        num_d        = DMG_TO_ACC[W-1:0];
        rem_d        = DMG_TO_ACC[W-1:0];
        tsf_target_d = TSF_TO_ACC;
        ur_d         = '0;
        abort_d      = 1'b0;
        state_d      = S_WAIT_TSF;
      end
      S_WAIT_TSF: begin
        if (launch) begin
          pkt_start = run;
          state_d   = (num_q == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        ACC_ASK_DATA = run & data_stb;
        if (data_stb) begin
          rem_d = rem_q - W'(1);
          ur_d  = '0;
          if (rem_q == W'(1)) state_d = S_DONE;
        end else if (stall) begin
          ur_d = ur_q + UR_CNT_W'(1);
          if (ur_q == UR_CNT_W'(UNDERRUN_TIMEOUT - 1)) begin
            abort_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        pkt_done     = run;
        underrun_err = run & abort_q;
        rr_last_d    = idx_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_queue_idx      = idx_q;
  assign cts_toself_config = cts_q;
  assign pkt_num_word      = num_q;

endmodule

// File: tb/tb_tx_queue_sched.sv
// Bench for tx_queue_sched: FIFO models with 1-cycle read latency around the DUT,
// table vectors, hand-written timing sequences and a randomized scheduler reference model.
module tb_tx_queue_sched;
  localparam int NW    = 14;
  localparam int TW    = 64;
  localparam int UR_TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          S_AXIS_ARESET;
  logic [2:0]    queue_en;
  logic          strict_prio;
  logic [2:0]    meta_empty;
  logic          EMPTYN_TO_ACC;
  logic [63:0]   DMG_TO_ACC;
  logic [TW-1:0] TSF_TO_ACC;
  logic [TW-1:0] tsf_now;
  logic          tx_phy_ready;
  logic          data_req;
  logic [1:0]    tx_queue_idx;
  logic          ACC_ASK_DMG, ACC_ASK_TSF, ACC_ASK_DATA;
  logic [31:0]   cts_toself_config;
  logic [NW-1:0] pkt_num_word;
  logic          pkt_start, pkt_done, underrun_err, busy;

  tx_queue_sched #(
    .MAX_BIT_NUM_DMA_SYMBOL(NW), .TSF_TIMER_WIDTH(TW),
    .UNDERRUN_TIMEOUT(UR_TO), .UR_CNT_W(10)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(S_AXIS_ARESET), .queue_en(queue_en),
    .strict_prio(strict_prio), .meta_empty(meta_empty), .EMPTYN_TO_ACC(EMPTYN_TO_ACC),
    .DMG_TO_ACC(DMG_TO_ACC), .TSF_TO_ACC(TSF_TO_ACC), .tsf_now(tsf_now),
    .tx_phy_ready(tx_phy_ready), .data_req(data_req), .tx_queue_idx(tx_queue_idx),
    .ACC_ASK_DMG(ACC_ASK_DMG), .ACC_ASK_TSF(ACC_ASK_TSF), .ACC_ASK_DATA(ACC_ASK_DATA),
    .cts_toself_config(cts_toself_config), .pkt_num_word(pkt_num_word),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .underrun_err(underrun_err), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] dmg;
    logic [63:0] tsf;
  } meta_t;

  typedef struct {
    logic [2:0] en;
    logic [2:0] mask;
    logic       strict;
    int         n;
    int         avail;
    longint     tsf;
    int         exp_idx;   // 3 = no grant expected
    int         exp_data;
    int         exp_ur;
  } vec_t;

  meta_t mem [3][16];
  int    wr [3];
  int    rd [3];
  int    data_cnt [3];
  meta_t cur;
  bit    pend_vld, tsf_run, model_on;
  int    model_last;

  int tests, fails, cyc;
  int n_pop, n_data, n_start, n_done, n_ur, n_tsf_ask, pkt_data;
  int t_pop, t_start, t_done, t_last_data;
  longint unsigned tsf_pop, tsf_start;
  logic [31:0]   done_cts;
  logic [NW-1:0] done_num;
  int served [64];

  logic          s_busy, s_any;
  logic [1:0]    s_idx;
  logic [31:0]   s_cts;
  logic [NW-1:0] s_num;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scheduler rule: strict = lowest eligible index; otherwise first eligible after the last served.
  function automatic int pick(input bit strict, input logic [2:0] elig, input int last);
    if (elig == 3'b000) return 3;
    if (strict) begin
      for (int i = 0; i < 3; i++) if (elig[i]) return i;
    end
    for (int k = 1; k <= 3; k++) if (elig[(last + k) % 3]) return (last + k) % 3;
    return 3;
  endfunction

  task automatic push(input int q, input logic [63:0] dmg, input logic [63:0] tsf);
    mem[q][wr[q] % 16].dmg = dmg;
    mem[q][wr[q] % 16].tsf = tsf;
    wr[q]++;
  endtask

  task automatic drive_env();
    int qi;
    for (int q = 0; q < 3; q++) meta_empty[q] = (wr[q] == rd[q]);
    qi = int'(tx_queue_idx);
    EMPTYN_TO_ACC = (qi < 3) ? (data_cnt[qi] > 0) : 1'b0;
  endtask

  task automatic clear_stats();
    n_pop = 0; n_data = 0; n_start = 0; n_done = 0; n_ur = 0; n_tsf_ask = 0; pkt_data = 0;
    t_pop = -1; t_start = -1; t_done = -1; t_last_data = -1;
    model_last = 2;
  endtask

  // One clock: observe outputs at the falling edge, update the FIFO models, drive after the rising edge.
  task automatic step();
    int q;
    longint exp_off;
    @(negedge clk);
    q      = int'(tx_queue_idx);
    s_busy = busy; s_idx = tx_queue_idx; s_cts = cts_toself_config; s_num = pkt_num_word;
    s_any  = ACC_ASK_DMG | ACC_ASK_TSF | ACC_ASK_DATA | pkt_start | pkt_done | underrun_err;
    if (ACC_ASK_TSF) n_tsf_ask++;
    if (ACC_ASK_DMG) begin
      if (model_on) chk("rand_grant_idx", q, pick(strict_prio, queue_en & ~meta_empty, model_last));
      if (n_pop < 64) served[n_pop] = q;
      n_pop++; t_pop = cyc; tsf_pop = tsf_now; pkt_data = 0;
      if (q < 3 && wr[q] != rd[q]) begin
        cur = mem[q][rd[q] % 16];
        rd[q]++;
      end
      pend_vld = 1'b1;
    end
    if (ACC_ASK_DATA) begin
      n_data++; pkt_data++; t_last_data = cyc;
      if (q < 3 && data_cnt[q] > 0) data_cnt[q]--;
    end
    if (pkt_start) begin
      n_start++; t_start = cyc; tsf_start = tsf_now;
      if (model_on) begin
        if (cur.tsf == 64'd0 || cur.tsf <= tsf_pop + 2) exp_off = 2;
        else exp_off = longint'(cur.tsf - tsf_pop);
        chk("rand_launch_cycle", longint'(t_start - t_pop), exp_off);
      end
    end
    if (underrun_err) n_ur++;
    if (pkt_done) begin
      n_done++; t_done = cyc; done_cts = cts_toself_config; done_num = pkt_num_word;
      if (model_on) begin
        chk("rand_data_words", pkt_data, longint'(cur.dmg[NW-1:0]));
        chk("rand_cts", done_cts, longint'(cur.dmg[63:32]));
        chk("rand_num_word", done_num, longint'(cur.dmg[NW-1:0]));
        chk("rand_underrun", underrun_err, 0);
        model_last = q;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tsf_run) tsf_now = tsf_now + 1;
    if (pend_vld) begin
      DMG_TO_ACC = cur.dmg;
      TSF_TO_ACC = cur.tsf;
      pend_vld   = 1'b0;
    end
    drive_env();
  endtask

  task automatic do_reset();
    S_AXIS_ARESET = 1'b1; tx_phy_ready = 1'b0; data_req = 1'b0; queue_en = 3'b000;
    strict_prio = 1'b0; tsf_run = 1'b0; tsf_now = '0; model_on = 1'b0;
    for (int q = 0; q < 3; q++) begin wr[q] = 0; rd[q] = 0; data_cnt[q] = 0; end
    step(); step();
    S_AXIS_ARESET = 1'b0;
    clear_stats();
    drive_env();
  endtask

  task automatic run_done(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin step(); k++; end
    chk({name, "_finished"}, longint'(n_done >= target), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   exp_order [6];
    int   exp_pops, k;
    logic [63:0] d;

    tests = 0; fails = 0; cyc = 0; pend_vld = 1'b0;
    DMG_TO_ACC = '0; TSF_TO_ACC = '0; EMPTYN_TO_ACC = 1'b0; meta_empty = 3'b111;

    // Reset state.
    do_reset();
    step();
    chk("rst_busy", s_busy, 0); chk("rst_idx", s_idx, 0); chk("rst_cts", s_cts, 0);
    chk("rst_num_word", s_num, 0); chk("rst_strobes", s_any, 0);

    // q1 only, 4 words, immediate launch: exact cycle timing.
    do_reset();
    queue_en = 3'b111; data_req = 1'b1; tx_phy_ready = 1'b1;
    push(1, {32'hA5A5_0001, 32'd4}, 64'd0); data_cnt[1] = 4; drive_env();
    k = cyc;
    run_done("t1", 1, 40);
    chk("t1_idx", served[0], 1); chk("t1_pop_cycle", t_pop - k, 1);
    chk("t1_pops", n_pop, 1); chk("t1_tsf_asks", n_tsf_ask, 1);
    chk("t1_start_cycle", t_start - k, 3); chk("t1_data", n_data, 4);
    chk("t1_done_cycle", t_done - k, 8); chk("t1_cts", done_cts, 32'hA5A5_0001);
    chk("t1_num_word", done_num, 4); chk("t1_underrun", n_ur, 0);

    // Round-robin from reset over three full queues.
    do_reset();
    queue_en = 3'b111; data_req = 1'b1; tx_phy_ready = 1'b1;
    for (int q = 0; q < 3; q++) begin
      push(q, {32'h100 + 32'(q), 32'd2}, 64'd0); push(q, {32'h200 + 32'(q), 32'd2}, 64'd0);
      data_cnt[q] = 4;
    end
    drive_env();
    run_done("t2", 6, 200);
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) chk($sformatf("t2_order%0d", i), served[i], exp_order[i]);

    // Strict priority with q0 and q2 loaded.
    do_reset();
    queue_en = 3'b111; strict_prio = 1'b1; data_req = 1'b1; tx_phy_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin push(0, 64'd1, 64'd0); push(2, 64'd1, 64'd0); end
    data_cnt[0] = 2; data_cnt[2] = 2; drive_env();
    run_done("t3", 4, 100);
    exp_order = '{0, 0, 2, 2, 0, 0};
    for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), served[i], exp_order[i]);

    // TSF-held launch.
    do_reset();
    queue_en = 3'b001; data_req = 1'b1; tx_phy_ready = 1'b1; tsf_now = 64'd990; tsf_run = 1'b1;
    push(0, 64'd1, 64'd1000); data_cnt[0] = 1; drive_env();
    k = cyc;
    run_done("t4", 1, 60);
    chk("t4_tsf_at_start", longint'(tsf_start), 1000); chk("t4_start_cycle", t_start - k, 10);
    chk("t4_data", n_data, 1);

    // Underrun: 8 words requested, 3 available.
    do_reset();
    queue_en = 3'b001; data_req = 1'b1; tx_phy_ready = 1'b1;
    push(0, 64'd8, 64'd0); data_cnt[0] = 3; drive_env();
    run_done("t5", 1, 80);
    chk("t5_data", n_data, 3); chk("t5_underrun", n_ur, 1);
    // 16 stalled cycles follow the last strobe; the abort pulse lands in the next one.
    chk("t5_done_after_last", t_done - t_last_data, UR_TO + 1);

    // Zero-length packet.
    do_reset();
    queue_en = 3'b001; data_req = 1'b1; tx_phy_ready = 1'b1;
    push(0, 64'd0, 64'd0); data_cnt[0] = 2; drive_env();
    run_done("t6", 1, 40);
    chk("t6_starts", n_start, 1); chk("t6_data", n_data, 0);
    chk("t6_done_cycle", t_done - t_start, 1);

    // Reset in the middle of STREAM.
    do_reset();
    queue_en = 3'b001; data_req = 1'b1; tx_phy_ready = 1'b1;
    push(0, {32'hBEEF_0000, 32'd8}, 64'd0); data_cnt[0] = 2; drive_env();
    k = 0;
    while (n_data < 2 && k < 30) begin step(); k++; end
    chk("t7_reached_stream", n_data, 2);
    step(); step();
    S_AXIS_ARESET = 1'b1;
    step(); step();
    chk("t7_busy", s_busy, 0); chk("t7_idx", s_idx, 0); chk("t7_cts", s_cts, 0);
    chk("t7_num_word", s_num, 0); chk("t7_strobes", s_any, 0);
    S_AXIS_ARESET = 1'b0; tx_phy_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t7_no_done", n_done, 0); chk("t7_idle", s_busy, 0);

    // Table vectors: one packet per queue in mask, first winner checked.
    vt[0] = '{3'b111, 3'b001, 1'b0, 3, 3, 0, 0, 3, 0};
    vt[1] = '{3'b111, 3'b100, 1'b1, 5, 5, 0, 2, 5, 0};
    vt[2] = '{3'b111, 3'b110, 1'b1, 2, 2, 0, 1, 2, 0};
    vt[3] = '{3'b111, 3'b110, 1'b0, 2, 2, 0, 1, 2, 0};
    vt[4] = '{3'b110, 3'b011, 1'b1, 1, 1, 0, 1, 1, 0};
    vt[5] = '{3'b011, 3'b100, 1'b0, 1, 1, 0, 3, 0, 0};
    vt[6] = '{3'b111, 3'b010, 1'b0, 4, 2, 0, 1, 2, 1};
    vt[7] = '{3'b111, 3'b001, 1'b0, 1, 1, 5, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      queue_en = vt[i].en; strict_prio = vt[i].strict; data_req = 1'b1;
      tx_phy_ready = 1'b1; tsf_run = 1'b1;
      for (int q = 0; q < 3; q++) begin
        if (vt[i].mask[q]) begin
          d = {32'hC0DE_0000 + 32'(i), 32'(vt[i].n)};
          push(q, d, 64'(vt[i].tsf)); data_cnt[q] = vt[i].avail;
        end
      end
      drive_env();
      if (vt[i].exp_idx == 3) begin
        for (int c = 0; c < 20; c++) step();
        chk($sformatf("vec%0d_no_grant", i), n_pop, 0);
      end else begin
        run_done($sformatf("vec%0d", i), 1, 80);
        chk($sformatf("vec%0d_idx", i), served[0], vt[i].exp_idx);
        chk($sformatf("vec%0d_data", i), n_data, vt[i].exp_data);
        chk($sformatf("vec%0d_underrun", i), n_ur, vt[i].exp_ur);
        chk($sformatf("vec%0d_num_word", i), done_num, vt[i].n);
      end
    end

    // Randomized rounds against the scheduler reference model.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      strict_prio = 1'($urandom_range(0, 1));
      queue_en    = 3'($urandom_range(1, 7));
      tsf_now     = 64'($urandom_range(0, 100));
      tsf_run     = 1'b1;
      model_on    = 1'b1;
      exp_pops    = 0;
      for (int q = 0; q < 3; q++) begin
        k = $urandom_range(1, 4);
        if (queue_en[q]) exp_pops += k;
        for (int j = 0; j < k; j++) begin
          d = {32'($urandom), 18'($urandom), 14'($urandom_range(0, 6))};
          push(q, d, ($urandom_range(0, 1) == 1) ? 64'd0 : tsf_now + 64'($urandom_range(0, 40)));
          data_cnt[q] += int'(d[NW-1:0]);
        end
      end
      drive_env();
      k = 0;
      while ((n_pop < exp_pops || n_done < exp_pops) && k < 2000) begin
        tx_phy_ready = ($urandom_range(0, 3) != 0);
        data_req     = ($urandom_range(0, 9) < 7);
        step();
        k++;
      end
      chk($sformatf("rand%0d_pops", r), n_pop, exp_pops);
      chk($sformatf("rand%0d_dones", r), n_done, exp_pops);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
